instruction_fetch_unit: RTL

- Fetch-side initiator for the byte-addressed, combinational-read instruction memory.
- Owns the program counter, drives the fetch address, and captures the returned 32-bit word into the IF/ID pipeline register.
- Handles hazard-unit stalls, branch/jump redirects with flush, and end-of-program detection.
- Sits between the instruction memory and the decode stage of the 5-stage pipeline.

---
 rtl/instruction_fetch_unit.sv | 124 ++++++++++++
 1 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the program counter, drives the fetch address
// to a combinational-read instruction memory and captures the returned word
// into the IF/ID pipeline register. Handles hazard stalls, EX-stage redirects
// (with IF/ID flush) and detects when fetch has run past the end of memory.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   RUN   | pc is inside the memory image; every unstalled edge fetches
//   DONE  | pc has run past the image; IF/ID drains to bubbles, pc holds
//
// A redirect always wins and is honoured from either state; it chooses
// RUN or DONE from whether the aligned target still fits in memory.
module instruction_fetch_unit #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter int unsigned MEM_BYTES = 88,
    parameter logic [31:0] NOP_INSN  = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [63:0] redirect_pc_i,
    output logic [63:0] inst_address,
    input  logic [63:0] instruction,
    output logic [63:0] if_id_pc,
    output logic [31:0] if_id_instruction,
    output logic        if_id_valid,
    output logic        fetch_done,
    output logic [31:0] fetch_count
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    localparam logic [63:0] MEM_BYTES_64 = 64'(MEM_BYTES);
    localparam logic [31:0] COUNT_MAX    = 32'hFFFF_FFFF;

    // pc + 4 <= MEM_BYTES, evaluated as pc <= MEM_BYTES - 4 so that a pc
    // near 2^64 cannot wrap into range.
    function automatic logic fetch_fits(input logic [63:0] addr);
        return (MEM_BYTES_64 >= 64'd4) && (addr <= (MEM_BYTES_64 - 64'd4));
    endfunction

    state_t      state_q,       state_d;
    logic [63:0] pc_q,          pc_d;
    logic [63:0] if_id_pc_q,    if_id_pc_d;
    logic [31:0] if_id_insn_q,  if_id_insn_d;
    logic        if_id_valid_q, if_id_valid_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic [63:0] pc_inc;
    logic [63:0] redirect_target;
    logic        pc_fits;

    // Upper instruction half and redirect byte offset are deliberately dropped.
    logic unused_bits;
    assign unused_bits = ^{instruction[63:32], redirect_pc_i[1:0]};

    assign pc_inc          = pc_q + 64'd4;
    assign redirect_target = {redirect_pc_i[63:2], 2'b00};
    assign pc_fits         = fetch_fits(pc_q);

    // Next-state and next-register computation: redirect > stall > advance.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_insn_d  = if_id_insn_q;
        if_id_valid_d = if_id_valid_q;
        fetch_count_d = fetch_count_q;

        if (redirect_i) begin
            pc_d          = redirect_target;
            if_id_insn_d  = NOP_INSN;
            if_id_valid_d = 1'b0;
            state_d       = fetch_fits(redirect_target) ? ST_RUN : ST_DONE;
        end else if (stall_i) begin
            // everything holds, including state
        end else if ((state_q == ST_RUN) && pc_fits) begin
            if_id_insn_d  = instruction[31:0];
            if_id_pc_d    = pc_q;
            if_id_valid_d = 1'b1;
            pc_d          = pc_inc;
            fetch_count_d = (fetch_count_q == COUNT_MAX) ? fetch_count_q
                                                         : fetch_count_q + 32'd1;
            // pc_q fits, so pc_inc cannot have wrapped here.
            state_d       = fetch_fits(pc_inc) ? ST_RUN : ST_DONE;
        end else begin
            // DONE, or RUN with an out-of-range pc: drain IF/ID to bubbles.
            state_d       = ST_DONE;
            if_id_insn_d  = NOP_INSN;
            if_id_valid_d = 1'b0;
        end
    end

    // State, PC, IF/ID and counter registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_PC;
            if_id_pc_q    <= 64'h0;
            if_id_insn_q  <= NOP_INSN;
            if_id_valid_q <= 1'b0;
            fetch_count_q <= 32'h0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_insn_q  <= if_id_insn_d;
            if_id_valid_q <= if_id_valid_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign inst_address      = pc_q;
    assign if_id_pc          = if_id_pc_q;
    assign if_id_instruction = if_id_insn_q;
    assign if_id_valid       = if_id_valid_q;
    assign fetch_done        = (state_q == ST_DONE);
    assign fetch_count       = fetch_count_q;

endmodule
